// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_W       = 2;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] RST_PC     = 32'h0000_0000;
  localparam logic                   RST_ENABLE = 1'b1;
  localparam logic [INST_ADDR_W-1:0] WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [INST_ADDR_W-1:0] PC_STEP    = 32'd4;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_e;

  // Payload handed to the if_id pipeline register.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } if_out_t;

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter: reset, redirect and +4 advance (rst > branch > advance).
module pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RST_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch,
  input  logic [INST_ADDR_W-1:0] branch_target,
  input  logic                   advance,
  output logic [INST_ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc <= RESET_PC & WORD_MASK;
    end else if (branch) begin
      pc <= branch_target & WORD_MASK;
    end else if (advance) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each word from four byte reads and presents it to if_id.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RST_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [BYTE_W-1:0]      mem_rdata,
  output logic                   if_valid,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst
);

  if_state_e              state;
  logic [CNT_W-1:0]       byte_cnt;
  logic [23:0]            inst_buf;
  logic [BYTE_W-1:0]      hold_byte;
  logic [INST_ADDR_W-1:0] pc;
  if_out_t                out_q;
  logic                   last_ack;
  logic                   slot_free;
  logic                   advance;

  assign mem_req  = (state == IF_FETCH);
  assign mem_addr = pc + {30'b0, byte_cnt};

  assign last_ack  = (state == IF_FETCH) && mem_ack && (byte_cnt == 2'd3);
  assign slot_free = !if_valid || !stall_i;
  assign advance   = !branch_i && ((last_ack && slot_free) || (state == IF_HOLD && !stall_i));

  assign if_pc   = out_q.pc;
  assign if_inst = out_q.inst;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch_i),
    .branch_target (branch_target_i),
    .advance       (advance),
    .pc            (pc)
  );

  // FSM, byte assembly and output register; redirect discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= IF_FETCH;
      byte_cnt  <= '0;
      inst_buf  <= '0;
      hold_byte <= '0;
      if_valid  <= 1'b0;
      out_q     <= '{pc: ZERO_WORD, inst: ZERO_WORD};
    end else if (branch_i) begin
      state    <= IF_FETCH;
      byte_cnt <= '0;
      if_valid <= 1'b0;
    end else begin
      if (if_valid && !stall_i) begin
        if_valid <= 1'b0;
      end
      case (state)
        IF_FETCH: begin
          if (mem_ack) begin
            case (byte_cnt)
              2'd0: inst_buf[7:0]   <= mem_rdata;
              2'd1: inst_buf[15:8]  <= mem_rdata;
              2'd2: inst_buf[23:16] <= mem_rdata;
              default: ;
            endcase
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
            end else if (slot_free) begin
              if_valid <= 1'b1;
              out_q    <= '{pc: pc, inst: {mem_rdata, inst_buf}};
              byte_cnt <= '0;
            end else begin
              hold_byte <= mem_rdata;
              state     <= IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (!stall_i) begin
            if_valid <= 1'b1;
            out_q    <= '{pc: pc, inst: {hold_byte, inst_buf}};
            byte_cnt <= '0;
            state    <= IF_FETCH;
          end
        end
        default: state <= IF_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: two instances (RESET_PC 0 and FFFF_FFFC) against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        ack;

  logic        req   [2];
  logic [31:0] addr  [2];
  logic [7:0]  rdata [2];
  logic        valid [2];
  logic [31:0] opc   [2];
  logic [31:0] oinst [2];

  logic [7:0]  mem [256];

  // Reference model state: words already fetched but not yet consumed, next byte address, bytes in flight.
  exp_t        sbq [2][$];
  logic [31:0] fp  [2];
  int          nb  [2];
  logic        rst_q;

  int n_chk;
  int n_fail;
  int exp_lat;
  int rel;
  bit seen;
  int stim_tmo;
  int tmo_seen;

  assign rdata[0] = mem[addr[0][7:0]];
  assign rdata[1] = mem[addr[1][7:0]];

  if_fetch dut0 (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch), .branch_target_i(target),
    .mem_req(req[0]), .mem_addr(addr[0]), .mem_ack(ack), .mem_rdata(rdata[0]),
    .if_valid(valid[0]), .if_pc(opc[0]), .if_inst(oinst[0])
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch), .branch_target_i(target),
    .mem_req(req[1]), .mem_addr(addr[1]), .mem_ack(ack), .mem_rdata(rdata[1]),
    .if_valid(valid[1]), .if_pc(opc[1]), .if_inst(oinst[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rpc(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  // Little-endian word as stored in memory starting at byte address a.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[8'(a + 32'd3)], mem[8'(a + 32'd2)], mem[8'(a + 32'd1)], mem[8'(a)]};
  endfunction

  // Reference model: advances once per rising edge from the inputs applied in that cycle.
  initial begin
    bit fetching;
    forever begin
      @(posedge clk);
      rst_q = rst;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          sbq[k].delete();
          fp[k] = rpc(k);
          nb[k] = 0;
        end else if (branch) begin
          sbq[k].delete();
          fp[k] = target & 32'hFFFF_FFFC;
          nb[k] = 0;
        end else begin
          fetching = (sbq[k].size() < 2);
          if (sbq[k].size() > 0 && !stall) void'(sbq[k].pop_front());
          if (fetching && ack) begin
            if (nb[k] == 3) begin
              sbq[k].push_back('{pc: fp[k] - 32'd3, inst: word_at(fp[k] - 32'd3)});
              nb[k] = 0;
            end else begin
              nb[k] = nb[k] + 1;
            end
            fp[k] = fp[k] + 32'd1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %08h, expected %08h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("if_valid", k, 32'(valid[k]), 32'(sbq[k].size() > 0));
        if (valid[k] && sbq[k].size() > 0) begin
          check("if_pc", k, opc[k], sbq[k][0].pc);
          check("if_inst", k, oinst[k], sbq[k][0].inst);
        end
        check("mem_req", k, 32'(req[k]), 32'(sbq[k].size() < 2));
        if (sbq[k].size() < 2) check("mem_addr", k, addr[k], fp[k]);
      end
      if (rst_q) begin
        rel  = 0;
        seen = 1'b0;
      end else begin
        rel++;
      end
      if (exp_lat >= 0 && !seen && !rst_q && valid[0]) begin
        check("first_valid_cycle", 0, 32'(rel), 32'(exp_lat));
        seen = 1'b1;
      end
      if (exp_lat >= 0 && !seen && rel == 200) begin
        check("first_valid_timeout", 0, 32'(rel), 32'(exp_lat));
        seen = 1'b1;
      end
      if (stim_tmo != tmo_seen) begin
        check("stimulus_wait", 0, 32'(stim_tmo), 32'(tmo_seen));
        tmo_seen = stim_tmo;
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic b, input logic a, input logic [31:0] t);
    rst = r; stall = s; branch = b; ack = a; target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wait_valid0(input logic s);
    int n;
    n = 0;
    while (!valid[0]) begin
      if (n++ > 60) begin stim_tmo++; return; end
      step(1'b0, s, 1'b0, 1'b1, 32'h0);
    end
  endtask

  initial begin
    logic        r, s, b, a;
    logic [31:0] t;
    int          n;
    n_chk = 0; n_fail = 0; exp_lat = -1; rel = 0; seen = 1'b0;
    stim_tmo = 0; tmo_seen = 0; rst_q = 1'b1;
    rst = 1'b1; stall = 1'b0; branch = 1'b0; ack = 1'b0; target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;

    // Ack every cycle: first word 0x00500013 at pc 0 in cycle 4.
    exp_lat = 4;
    do_reset();
    repeat (14) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Three idle cycles before every byte: first valid in cycle 16.
    exp_lat = 16;
    do_reset();
    repeat (20) begin
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    end

    // Stall ten cycles on the first output; second word waits in HOLD.
    exp_lat = 4;
    do_reset();
    wait_valid0(1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Redirect to 0x103 during byte 2 of the fetch at 8.
    exp_lat = -1;
    do_reset();
    n = 0;
    while (addr[0] != 32'h0000_000A) begin
      if (n++ > 60) begin stim_tmo++; break; end
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Redirect coinciding with the fourth ack while the output is stalled.
    do_reset();
    wait_valid0(1'b0);
    n = 0;
    while (!(req[0] && addr[0][1:0] == 2'd3)) begin
      if (n++ > 60) begin stim_tmo++; break; end
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Reset pulsed mid-fetch, then wrap-around from FFFF_FFFC.
    do_reset();
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    repeat (14) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Randomized traffic: acks, stalls, redirects (some near the top of memory) and rare resets.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 9) < 7);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 255));
      step(r, s, b, a, t);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
